// File: rtl/hid_pkg.sv
// Shared definitions for the HID keyboard event path: event layout, device/modifier codes, scan FSM states.
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a.
package hid_pkg;

    // Event word layout: {repeat, press, code[7:0]}
    localparam int EVT_W         = 10;
    localparam int EVT_CODE_LSB  = 0;
    localparam int EVT_PRESS_BIT = 8;
    localparam int EVT_RPT_BIT   = 9;

    localparam logic [1:0] HID_DEV_KEYBOARD = 2'd1;
    localparam logic [7:0] HID_MOD_BASE     = 8'hE0;

    // Usage codes 0x01..0x03 mean phantom/rollover/error; such a report carries no key state
    localparam logic [7:0] HID_ROLLOVER_MIN = 8'h01;
    localparam logic [7:0] HID_ROLLOVER_MAX = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_REL_SCAN,
        ST_MOD_SCAN,
        ST_PRS_SCAN,
        ST_COMMIT
    } scan_state_t;

    // Four key slots, index 0 = key1
    typedef logic [3:0][7:0] key_set_t;

    function automatic logic key_in_set(input logic [7:0] code, input key_set_t keys);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (keys[i] == code) hit = 1'b1;
        end
        return hit;
    endfunction

    // True when slot idx repeats a code already held in a lower slot
    function automatic logic dup_before(input key_set_t keys, input logic [1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i < int'(idx) && keys[i] == keys[idx]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic has_rollover(input key_set_t keys);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (keys[i] >= HID_ROLLOVER_MIN && keys[i] <= HID_ROLLOVER_MAX) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [EVT_W-1:0] mk_evt(input logic rpt, input logic press, input logic [7:0] code);
        logic [EVT_W-1:0] e;
        e = '0;
        e[EVT_RPT_BIT]          = rpt;
        e[EVT_PRESS_BIT]        = press;
        e[EVT_CODE_LSB +: 8]    = code;
        return e;
    endfunction

endpackage

// File: rtl/hid_evt_fifo.sv
// First-word-fall-through event FIFO; head is presented whenever the FIFO is non-empty.
// Latency: a push is visible on rd_dat/rd_vld the cycle after it is written.
// Backpressure: pops only on rd_vld&&rd_rdy; a push into a full FIFO is refused unless a pop happens in the same cycle.
module hid_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     wb_clk,
    input  logic                     sys_rst,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign rd_vld = (level != '0);
    assign full   = (level == (AW+1)'(DEPTH));
    assign rd_dat = mem[rd_ptr];
    assign do_rd  = rd_vld && rd_rdy;
    // When full, the slot being popped this cycle is the one written, so the push is safe
    assign do_wr  = wr_vld && (!full || do_rd);

    // Storage array, no reset needed: contents are qualified by level
    always_ff @(posedge wb_clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge wb_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)      level <= level + 1'b1;
            else if (!do_wr && do_rd) level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/hid_key_event_gen.sv
// Turns HID keyboard reports into press/release events by diffing against the previous report (auto-repeat with KBD_TYPEMATIC_EN).
// Latency: strobe at T -> CAPTURE T+1, first push T+2, evt_valid T+3, back to IDLE T+19; one report may wait in a pending slot.
// Backpressure: scanning never stalls; events that meet a full FIFO are dropped and flagged in sticky overflow.
module hid_key_event_gen
    import hid_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic                          wb_clk,
    input  logic                          sys_rst,
    input  logic                          report_stb,
    input  logic [1:0]                    dev_typ,
    input  logic [7:0]                    key_modifiers,
    input  logic [7:0]                    key1,
    input  logic [7:0]                    key2,
    input  logic [7:0]                    key3,
    input  logic [7:0]                    key4,
    output logic [9:0]                    evt_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic                          busy
);

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("hid_key_event_gen: FIFO_DEPTH must be a power of two >= 4");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("hid_key_event_gen: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    scan_state_t      state, state_nxt;
    logic [2:0]       idx;
    key_set_t         in_keys, cur_keys, prev_keys, pend_keys;
    logic [7:0]       cur_mods, prev_mods, pend_mods;
    logic             pend_vld;
    logic             kbd_stb, take_stb, take_pend, to_pend;
    logic             scan_push;
    logic [EVT_W-1:0] scan_dat;
    logic             rpt_push;
    logic [EVT_W-1:0] rpt_dat;
    logic             evt_push;
    logic [EVT_W-1:0] evt_dat;
    logic             fifo_full;
    logic             evt_pop;
    logic             ovf_set;
    logic [7:0]       old_key, new_key;

    assign in_keys   = {key4, key3, key2, key1};
    assign kbd_stb   = report_stb && (dev_typ == HID_DEV_KEYBOARD);
    // A pending report is consumed whenever the FSM can start a new capture
    assign take_pend = pend_vld && (state == ST_IDLE || state == ST_COMMIT);
    assign take_stb  = kbd_stb && (state == ST_IDLE) && !pend_vld;
    assign to_pend   = kbd_stb && !take_stb;
    assign busy      = (state != ST_IDLE) || pend_vld;
    assign old_key   = prev_keys[idx[1:0]];
    assign new_key   = cur_keys[idx[1:0]];

    // State register and per-phase slot/bit index
    always_ff @(posedge wb_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= (state_nxt == state && state != ST_IDLE) ? idx + 3'd1 : 3'd0;
        end
    end

    // Next-state and diff event generation; one candidate event per scan cycle
    always_comb begin
        state_nxt = state;
        scan_push = 1'b0;
        scan_dat  = '0;
        case (state)
            ST_IDLE: begin
                if (take_pend || take_stb) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // A rollover/error report is discarded whole; prev state stays as it was
                state_nxt = has_rollover(cur_keys) ? ST_IDLE : ST_REL_SCAN;
            end
            ST_REL_SCAN: begin
                // Duplicate old slots are released once only
                if (old_key != 8'h00 && !key_in_set(old_key, cur_keys) && !dup_before(prev_keys, idx[1:0])) begin
                    scan_push = 1'b1;
                    scan_dat  = mk_evt(1'b0, 1'b0, old_key);
                end
                if (idx == 3'd3) state_nxt = ST_MOD_SCAN;
            end
            ST_MOD_SCAN: begin
                if (prev_mods[idx] != cur_mods[idx]) begin
                    scan_push = 1'b1;
                    scan_dat  = mk_evt(1'b0, cur_mods[idx], HID_MOD_BASE + {5'b0, idx});
                end
                if (idx == 3'd7) state_nxt = ST_PRS_SCAN;
            end
            ST_PRS_SCAN: begin
                if (new_key != 8'h00 && !key_in_set(new_key, prev_keys) && !dup_before(cur_keys, idx[1:0])) begin
                    scan_push = 1'b1;
                    scan_dat  = mk_evt(1'b0, 1'b1, new_key);
                end
                if (idx == 3'd3) state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_nxt = take_pend ? ST_CAPTURE : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Report capture, pending slot, previous-report commit and sticky overflow
    always_ff @(posedge wb_clk) begin
        if (sys_rst) begin
            cur_keys  <= '0;
            cur_mods  <= '0;
            prev_keys <= '0;
            prev_mods <= '0;
            pend_keys <= '0;
            pend_mods <= '0;
            pend_vld  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (take_stb) begin
                cur_keys <= in_keys;
                cur_mods <= key_modifiers;
            end else if (take_pend) begin
                cur_keys <= pend_keys;
                cur_mods <= pend_mods;
            end
            if (to_pend) begin
                pend_keys <= in_keys;
                pend_mods <= key_modifiers;
            end
            pend_vld <= to_pend || (pend_vld && !take_pend);
            if (state == ST_COMMIT) begin
                prev_keys <= cur_keys;
                prev_mods <= cur_mods;
            end
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

`ifdef KBD_TYPEMATIC_EN
    logic        rpt_act;
    logic        rpt_due;
    logic [7:0]  rpt_code;
    logic [31:0] rpt_cnt;
    logic        rpt_fire;
    logic        rpt_arm;
    logic        rpt_rel;

    // A tick that collides with a scan push is held in rpt_due and issued in the next free cycle
    assign rpt_fire = rpt_act && (rpt_cnt == 32'd0 || rpt_due);
    assign rpt_push = rpt_fire && !scan_push;
    assign rpt_dat  = mk_evt(1'b1, 1'b1, rpt_code);
    assign rpt_arm  = scan_push && (state == ST_PRS_SCAN);
    assign rpt_rel  = scan_push && (state == ST_REL_SCAN) && (scan_dat[EVT_CODE_LSB +: 8] == rpt_code);

    // Typematic timer: retargets on every new press, stops when the repeat key is released
    always_ff @(posedge wb_clk) begin
        if (sys_rst) begin
            rpt_act  <= 1'b0;
            rpt_due  <= 1'b0;
            rpt_code <= '0;
            rpt_cnt  <= '0;
        end else if (rpt_arm) begin
            rpt_act  <= 1'b1;
            rpt_due  <= 1'b0;
            rpt_code <= scan_dat[EVT_CODE_LSB +: 8];
            rpt_cnt  <= 32'(REPEAT_DELAY - 1);
        end else if (rpt_rel) begin
            rpt_act <= 1'b0;
            rpt_due <= 1'b0;
        end else if (rpt_act) begin
            rpt_cnt <= (rpt_cnt == 32'd0) ? 32'(REPEAT_PERIOD - 1) : rpt_cnt - 32'd1;
            rpt_due <= rpt_fire && scan_push;
        end
    end
`else
    assign rpt_push = 1'b0;
    assign rpt_dat  = '0;
`endif

    assign evt_push = scan_push || rpt_push;
    assign evt_dat  = scan_push ? scan_dat : rpt_dat;
    assign evt_pop  = evt_valid && evt_ready;
    assign ovf_set  = evt_push && fifo_full && !evt_pop;

    hid_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .wb_clk  (wb_clk),
        .sys_rst (sys_rst),
        .wr_vld  (evt_push),
        .wr_dat  (evt_dat),
        .rd_vld  (evt_valid),
        .rd_rdy  (evt_ready),
        .rd_dat  (evt_data),
        .full    (fifo_full),
        .level   (fifo_level)
    );

endmodule

// File: tb/tb_hid_key_event_gen.sv
// Directed bench for hid_key_event_gen: report diffs, rollover rejection, pending overwrite, overflow, reset abort, repeat.
// Latency: checks strobe-relative event timing against the scan schedule.
// Backpressure: evt_ready held high except in the overflow case.
module tb_hid_key_event_gen;

    logic       wb_clk = 1'b0;
    logic       sys_rst;
    logic       report_stb;
    logic [1:0] dev_typ;
    logic [7:0] key_modifiers, key1, key2, key3, key4;
    logic [9:0] evt_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       ovf_clr;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t1;
    logic [9:0] evq[$];
    int         evc[$];

    hid_key_event_gen #(
        .FIFO_DEPTH    (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (4)
    ) dut (
        .wb_clk        (wb_clk),
        .sys_rst       (sys_rst),
        .report_stb    (report_stb),
        .dev_typ       (dev_typ),
        .key_modifiers (key_modifiers),
        .key1          (key1),
        .key2          (key2),
        .key3          (key3),
        .key4          (key4),
        .evt_data      (evt_data),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr),
        .busy          (busy)
    );

    always #5 wb_clk = ~wb_clk;

    always @(posedge wb_clk) cyc++;

    // Record every popped event with the cycle it was presented
    always @(negedge wb_clk) begin
        #1;
        if (evt_valid && evt_ready) begin
            evq.push_back(evt_data);
            evc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input int i);
        return (i < evq.size()) ? 32'(evq[i]) : 32'hDEAD;
    endfunction

    function automatic int evt_at(input int i);
        return (i < evc.size()) ? evc[i] : -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge wb_clk);
    endtask

    // Called at a negedge; returns at the negedge inside cycle T+1
    task automatic send(input logic [1:0] typ, input logic [7:0] m,
                        input logic [7:0] k1, input logic [7:0] k2, input logic [7:0] k3, input logic [7:0] k4);
        report_stb    = 1'b1;
        dev_typ       = typ;
        key_modifiers = m;
        key1 = k1; key2 = k2; key3 = k3; key4 = k4;
        tick(1);
        report_stb = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick(1);
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
        tick(3);
    endtask

    task automatic expect_evts(input string tag, input int n,
                               input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2, input logic [9:0] e3);
        logic [9:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({tag, "_count"}, 32'(evq.size()), 32'(n));
        for (int i = 0; i < n; i++) chk($sformatf("%s_%0d", tag, i), ev(i), 32'(e[i]));
        evq.delete();
        evc.delete();
    endtask

    initial begin
        sys_rst = 1'b1; report_stb = 1'b0; dev_typ = 2'd1; key_modifiers = '0;
        key1 = '0; key2 = '0; key3 = '0; key4 = '0;
        evt_ready = 1'b1; ovf_clr = 1'b0;
        tick(3);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        sys_rst = 1'b0;
        tick(2);

        // Single press from zero state: press lands in PRS slot 0 (push T+14, visible T+15)
        send(2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
        t1 = cyc;
        chk("first_busy", 32'(busy), 32'd1);
        tick(17);
        chk("commit_busy", 32'(busy), 32'd1);
        tick(1);
        chk("idle_t19", 32'(busy), 32'd0);
        chk("press_time", 32'(evt_at(0)), 32'(t1 + 14));
        expect_evts("press", 1, 10'h104, 10'h0, 10'h0, 10'h0);

        // Build prev {04,05} mods 0x02, then move to {05,06} mods 0x00
        send(2'd1, 8'h02, 8'h04, 8'h05, 8'h00, 8'h00);
        wait_idle();
        expect_evts("setup", 2, 10'h1E1, 10'h105, 10'h0, 10'h0);
        send(2'd1, 8'h00, 8'h05, 8'h06, 8'h00, 8'h00);
        t1 = cyc;
        wait_idle();
        chk("rel_time", 32'(evt_at(0)), 32'(t1 + 2));
        expect_evts("diff", 3, 10'h004, 10'h0E1, 10'h106, 10'h0);

        // Rollover report ignored; next report diffed against {05,06} mods 0
        send(2'd1, 8'h04, 8'h01, 8'h07, 8'h00, 8'h00);
        wait_idle();
        expect_evts("rollover", 0, 10'h0, 10'h0, 10'h0, 10'h0);
        send(2'd1, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00);
        wait_idle();
        expect_evts("post_err", 1, 10'h006, 10'h0, 10'h0, 10'h0);

        // Non-keyboard strobe is ignored
        send(2'd2, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00);
        chk("nonkbd_busy", 32'(busy), 32'd0);
        tick(20);
        expect_evts("nonkbd", 0, 10'h0, 10'h0, 10'h0, 10'h0);

        // A, middle M, B during A's scan: M is overwritten by B
        send(2'd1, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00);
        tick(3);
        send(2'd1, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00);
        tick(3);
        send(2'd1, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00);
        wait_idle();
        expect_evts("pend", 4, 10'h005, 10'h107, 10'h007, 10'h109);

        // Six modifier presses into a 4-deep FIFO with no consumer
        evt_ready = 1'b0;
        send(2'd1, 8'h3F, 8'h09, 8'h00, 8'h00, 8'h00);
        wait_idle();
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);
        chk("ovf_level_kept", 32'(fifo_level), 32'd4);
        evt_ready = 1'b1;
        tick(6);
        expect_evts("ovf", 4, 10'h1E0, 10'h1E1, 10'h1E2, 10'h1E3);
        chk("drained", 32'(fifo_level), 32'd0);

        // Reset mid-scan: nothing committed, next report diffed against zeros
        send(2'd1, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00);
        tick(5);
        sys_rst = 1'b1;
        tick(1);
        sys_rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_level", 32'(fifo_level), 32'd0);
        evq.delete();
        evc.delete();
        tick(2);
        send(2'd1, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h00);
        wait_idle();
        expect_evts("post_rst", 1, 10'h10B, 10'h0, 10'h0, 10'h0);

        // Hold 0x04 (press pushed at T+14), then release it
        send(2'd1, 8'h00, 8'h04, 8'h0B, 8'h00, 8'h00);
        t1 = cyc;
`ifdef KBD_TYPEMATIC_EN
        begin
            int n = 0;
            while (evq.size() < 4 && n < 100) begin
                tick(1);
                n++;
            end
        end
        chk("rpt_t0", 32'(evt_at(0)), 32'(t1 + 14));
        chk("rpt_t1", 32'(evt_at(1)), 32'(t1 + 24));
        chk("rpt_t2", 32'(evt_at(2)), 32'(t1 + 28));
        chk("rpt_t3", 32'(evt_at(3)), 32'(t1 + 32));
        expect_evts("rpt", 4, 10'h104, 10'h304, 10'h304, 10'h304);
        send(2'd1, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h00);
        wait_idle();
        tick(30);
        begin
            int rel_pos = -1;
            int after   = 0;
            for (int i = 0; i < evq.size(); i++) begin
                if (rel_pos < 0 && evq[i] == 10'h004) rel_pos = i;
                else if (rel_pos >= 0 && evq[i] == 10'h304) after++;
            end
            chk("rpt_rel_seen", 32'(rel_pos >= 0), 32'd1);
            chk("rpt_after_rel", 32'(after), 32'd0);
        end
        evq.delete();
        evc.delete();
`else
        wait_idle();
        tick(40);
        chk("hold_time", 32'(evt_at(0)), 32'(t1 + 14));
        expect_evts("hold", 1, 10'h104, 10'h0, 10'h0, 10'h0);
        send(2'd1, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h00);
        wait_idle();
        tick(20);
        expect_evts("release", 1, 10'h004, 10'h0, 10'h0, 10'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
